// File: rtl/hlsm_job_sched_if.sv
// Requester, response and kernel-side signals of the shared-kernel job scheduler.
// master = scheduler, slave = requesters/consumer/kernel environment.
interface hlsm_job_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*DATA_W-1:0] req_c;
  logic [NUM_REQ-1:0]        ack;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [DATA_W-1:0]         rsp_z;
  logic [DATA_W-1:0]         rsp_x;
  logic                      rsp_err;
  logic                      busy;

  logic                      k_start;
  logic [DATA_W-1:0]         k_a;
  logic [DATA_W-1:0]         k_b;
  logic [DATA_W-1:0]         k_c;
  logic                      k_done;
  logic [DATA_W-1:0]         k_z;
  logic [DATA_W-1:0]         k_x;

  modport master (
    input  req, req_a, req_b, req_c,
    input  rsp_ready, k_done, k_z, k_x,
    output ack, rsp_valid, rsp_id, rsp_z,
    output rsp_x, rsp_err, busy,
    output k_start, k_a, k_b, k_c
  );

  modport slave (
    output req, req_a, req_b, req_c,
    output rsp_ready, k_done, k_z, k_x,
    input  ack, rsp_valid, rsp_id, rsp_z,
    input  rsp_x, rsp_err, busy,
    input  k_start, k_a, k_b, k_c
  );
endinterface

// File: rtl/hlsm_job_sched.sv
// Round-robin scheduler sharing one Start/Done kernel among NUM_REQ requesters.
// One job in flight; operands held from grant until the next grant.
module hlsm_job_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic             Clk,
  input logic             Rst,
  hlsm_job_sched_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               kst_q, kst_d;
  logic [DATA_W-1:0]  ka_q, ka_d;
  logic [DATA_W-1:0]  kb_q, kb_d;
  logic [DATA_W-1:0]  kc_q, kc_d;
  logic               vld_q, vld_d;
  logic [IDW-1:0]     rid_q, rid_d;
  logic [DATA_W-1:0]  rz_q, rz_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [TW-1:0]      tmr_q, tmr_d;

  logic               pick_vld;
  logic [IDW-1:0]     pick;
  logic [IDW:0]       sum;

  // Walk offsets high to low so the nearest set bit at/after ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = ptr_q;
    sum      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ))
        sum = sum - (IDW+1)'(NUM_REQ);
      if (bus.req[sum[IDW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    kst_d   = 1'b0;
    ka_d    = ka_q;
    kb_d    = kb_q;
    kc_d    = kc_q;
    vld_d   = vld_q;
    rid_d   = rid_q;
    rz_d    = rz_q;
    rx_d    = rx_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          ka_d    = bus.req_a[int'(pick)*DATA_W +: DATA_W];
          kb_d    = bus.req_b[int'(pick)*DATA_W +: DATA_W];
          kc_d    = bus.req_c[int'(pick)*DATA_W +: DATA_W];
          ack_d   = NUM_REQ'(1) << pick;
          kst_d   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tmr_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (bus.k_done) begin
          rz_d    = bus.k_z;
          rx_d    = bus.k_x;
          err_d   = 1'b0;
          rid_d   = gnt_q;
          vld_d   = 1'b1;
          state_d = RESP;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          rz_d    = '0;
          rx_d    = '0;
          err_d   = 1'b1;
          rid_d   = gnt_q;
          vld_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      RESP: begin
        if (vld_q && bus.rsp_ready) begin
          vld_d   = 1'b0;
          ptr_d   = (gnt_q == IDW'(NUM_REQ - 1)) ?
                    '0 : gnt_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      kst_q   <= 1'b0;
      ka_q    <= '0;
      kb_q    <= '0;
      kc_q    <= '0;
      vld_q   <= 1'b0;
      rid_q   <= '0;
      rz_q    <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      kst_q   <= kst_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      kc_q    <= kc_d;
      vld_q   <= vld_d;
      rid_q   <= rid_d;
      rz_q    <= rz_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.k_start   = kst_q;
  assign bus.k_a       = ka_q;
  assign bus.k_b       = kb_q;
  assign bus.k_c       = kc_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_z     = rz_q;
  assign bus.rsp_x     = rx_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = busy_q;
endmodule
